pll_rst_seq: RTL

//  Sequences the fabric PLL and the system reset around it. Pulses the PLL reset and waits
//  for lock, retrying on timeout. Qualifies lock as stable, then holds system reset for a

---
 rtl/pll_rst_seq_pkg.sv | 38 +++
 rtl/sync_ff2.sv | 31 +++
 rtl/pll_rst_seq.sv | 139 +++++++++++++
 3 files changed

// File: rtl/pll_rst_seq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pll_rst_seq_pkg                                            |
// | Description : Shared types and sizing helpers for the PLL/reset          |
// |               sequencer. The FAIL encoding is always allocated so the    |
// |               state register width does not depend on the build option  |
// |               PLL_RST_SEQ_RETRY_LIMIT_EN.                                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package pll_rst_seq_pkg;

    // Sequencer states; 3-bit encoding with room for FAIL in every build
    typedef enum logic [2:0] {
        ST_PLLRST = 3'd0,
        ST_WAIT   = 3'd1,
        ST_STABLE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_RUN    = 3'd4,
        ST_FAIL   = 3'd5
    } state_t;

    // Width of the timeout/retry counter output
    localparam int RETRY_W = 8;

    // Shared counter width: one spare bit above the largest cycle parameter
    // so the terminal compare value always fits and saturation sits above it.
    function automatic int calc_cnt_w(input int pll_rst_cyc, input int lock_timeout,
                                      input int lock_stable, input int rst_hold);
        int m;
        m = pll_rst_cyc;
        if (lock_timeout > m) m = lock_timeout;
        if (lock_stable  > m) m = lock_stable;
        if (rst_hold     > m) m = rst_hold;
        return $clog2(m) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_ff2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sync_ff2                                                   |
// | Description : Generic single-bit two-flop synchronizer, reset to 0.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module sync_ff2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    // Two back-to-back flops resolve metastability on the asynchronous input
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/pll_rst_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pll_rst_seq                                                |
// | Description : PLL reset pulse, lock wait with retry, lock qualification  |
// |               and timed system-reset release. Loss of lock restarts the  |
// |               sequence. Define PLL_RST_SEQ_RETRY_LIMIT_EN to count       |
// |               timeouts and give up (sticky fail) after MAX_RETRY.        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module pll_rst_seq
    import pll_rst_seq_pkg::*;
#(
    parameter int PLL_RST_CYC  = 16,
    parameter int LOCK_TIMEOUT = 50000,
    parameter int LOCK_STABLE  = 1024,
    parameter int RST_HOLD     = 256
`ifdef PLL_RST_SEQ_RETRY_LIMIT_EN
    ,
    parameter int MAX_RETRY    = 7
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               locked,
    output logic               pll_rst,
    output logic               sys_rst,
    output logic               clk_ok
`ifdef PLL_RST_SEQ_RETRY_LIMIT_EN
    ,
    output logic [RETRY_W-1:0] retries,
    output logic               fail
`endif
);

    localparam int CNT_W = calc_cnt_w(PLL_RST_CYC, LOCK_TIMEOUT, LOCK_STABLE, RST_HOLD);

    localparam logic [CNT_W-1:0] c_pll_last    = CNT_W'(PLL_RST_CYC - 1);
    localparam logic [CNT_W-1:0] c_to_last     = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_stable_last = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] c_hold_last   = CNT_W'(RST_HOLD - 1);

    logic             w_lock_s;
    logic             w_timeout;
    state_t           r_state;
    state_t           w_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pll_rst;
    logic             r_sys_rst;
    logic             r_clk_ok;

    sync_ff2 u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (locked),
        .q   (w_lock_s)
    );

    // Lock wait expired with no lock this cycle (lock wins in the last cycle)
    assign w_timeout = (r_state == ST_WAIT) && !w_lock_s && (r_cnt == c_to_last);

`ifdef PLL_RST_SEQ_RETRY_LIMIT_EN
    logic [RETRY_W-1:0] r_retries;
    logic               r_fail;
    logic [RETRY_W-1:0] w_retries_inc;

    assign w_retries_inc = (r_retries == '1) ? r_retries : r_retries + RETRY_W'(1);
`endif

    // Next-state decision; loss of lock takes priority over terminal counts
    always_comb begin
        w_nxt = r_state;
        case (r_state)
            ST_PLLRST: if (r_cnt == c_pll_last) w_nxt = ST_WAIT;
            ST_WAIT: begin
                if (w_lock_s) begin
                    w_nxt = ST_STABLE;
                end else if (w_timeout) begin
`ifdef PLL_RST_SEQ_RETRY_LIMIT_EN
                    w_nxt = (w_retries_inc == RETRY_W'(MAX_RETRY)) ? ST_FAIL : ST_PLLRST;
`else
                    w_nxt = ST_PLLRST;
`endif
                end
            end
            ST_STABLE: begin
                if (!w_lock_s)                    w_nxt = ST_WAIT;
                else if (r_cnt == c_stable_last)  w_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (!w_lock_s)                    w_nxt = ST_PLLRST;
                else if (r_cnt == c_hold_last)    w_nxt = ST_RUN;
            end
            ST_RUN: if (!w_lock_s) w_nxt = ST_PLLRST;
`ifdef PLL_RST_SEQ_RETRY_LIMIT_EN
            ST_FAIL: w_nxt = ST_FAIL;
`endif
            default: w_nxt = ST_PLLRST;
        endcase
    end

    // State, shared counter and outputs; outputs follow the state being entered
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_PLLRST;
            r_cnt     <= '0;
            r_pll_rst <= 1'b1;
            r_sys_rst <= 1'b1;
            r_clk_ok  <= 1'b0;
`ifdef PLL_RST_SEQ_RETRY_LIMIT_EN
            r_retries <= '0;
            r_fail    <= 1'b0;
`endif
        end else begin
            r_state <= w_nxt;
            if (w_nxt != r_state) begin
                r_cnt <= '0;
            end else if (r_cnt != '1) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            r_pll_rst <= (w_nxt == ST_PLLRST) || (w_nxt == ST_FAIL);
            r_sys_rst <= (w_nxt != ST_RUN);
            r_clk_ok  <= (w_nxt == ST_RUN);
`ifdef PLL_RST_SEQ_RETRY_LIMIT_EN
            if (w_timeout) r_retries <= w_retries_inc;
            r_fail <= (w_nxt == ST_FAIL);
`endif
        end
    end

    assign pll_rst = r_pll_rst;
    assign sys_rst = r_sys_rst;
    assign clk_ok  = r_clk_ok;
`ifdef PLL_RST_SEQ_RETRY_LIMIT_EN
    assign retries = r_retries;
    assign fail    = r_fail;
`endif

endmodule
`default_nettype wire
